// File: rtl/qspi_arb.sv
// qspi_arb: shares one QSPI memory controller between three cache-side
// requesters (icache fill, dcache fill, dcache dirty-line writeback).
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   i_req/i_addr/i_mem/i_ack   icache fill request, line address, chip index, done pulse
//   d_req/d_addr/d_mem/d_ack   dcache fill, same shape
//   w_req/w_addr/w_mem/w_ack   dcache writeback, same shape
//   err                        pulses with an ack when the request targeted mem==3
//   q_req/q_i_d/q_mem/q_write/q_paddr  held request towards the controller
//   q_wstrobe_i/q_wstrobe_d    controller read-nibble strobes (instruction/data side)
//   q_rstrobe_d                controller write-nibble strobe
//   q_cs                       controller chip selects, active low
//   busy                       high whenever the FSM is not IDLE
//   dbg_state                  current FSM state (IDLE=0, GRANT=1, DRAIN=2, ACK=3)
//
// Handshake: a requester raises req with addr/mem stable and holds them until
// its ack pulse; it must drop req in the cycle after the ack or it is taken as
// a new request. The block holds q_req high from the grant until the last
// nibble strobe; q_paddr/q_mem/q_write/q_i_d stay stable until the next grant.
module qspi_arb #(
    parameter int PA          = 24,
    parameter int LINE_LENGTH = 4,
    localparam int AW         = PA - $clog2(LINE_LENGTH),
    localparam int CW         = $clog2(2 * LINE_LENGTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    input  logic [1:0]    i_mem,
    output logic          i_ack,
    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    input  logic [1:0]    d_mem,
    output logic          d_ack,
    input  logic          w_req,
    input  logic [AW-1:0] w_addr,
    input  logic [1:0]    w_mem,
    output logic          w_ack,
    output logic          err,
    output logic          q_req,
    output logic          q_i_d,
    output logic [1:0]    q_mem,
    output logic          q_write,
    output logic [AW-1:0] q_paddr,
    input  logic          q_wstrobe_i,
    input  logic          q_wstrobe_d,
    input  logic          q_rstrobe_d,
    input  logic [2:0]    q_cs,
    output logic          busy,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, DRAIN = 2'd2, ACK = 2'd3} state_t;
    typedef enum logic [1:0] {WIN_I = 2'd0, WIN_D = 2'd1, WIN_W = 2'd2} win_t;

    state_t        state, state_nxt;
    win_t          win, pick;
    logic          rr_last;
    logic [CW-1:0] cnt;

    logic          i_ok, d_ok, w_ok, any_ok;
    logic [AW-1:0] sel_addr;
    logic [1:0]    sel_mem;
    logic          strobe, last_strobe;

    // A requester whose ack is showing this cycle is still holding req for
    // one more cycle; mask it so the same line is not served twice.
    assign i_ok   = i_req & ~i_ack;
    assign d_ok   = d_req & ~d_ack;
    assign w_ok   = w_req & ~w_ack;
    assign any_ok = i_ok | d_ok | w_ok;

    // Only the strobe matching the latched direction and side counts.
    assign strobe      = q_write ? q_rstrobe_d : (q_i_d ? q_wstrobe_i : q_wstrobe_d);
    assign last_strobe = strobe && (cnt == CW'(2 * LINE_LENGTH - 1));

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // Writeback first; fills round-robin, favouring the one not granted last.
    always_comb begin
        pick     = WIN_I;
        sel_addr = i_addr;
        sel_mem  = i_mem;
        if (w_ok) begin
            pick = WIN_W;
        end else if (i_ok && d_ok) begin
            pick = rr_last ? WIN_I : WIN_D;
        end else if (d_ok) begin
            pick = WIN_D;
        end
        case (pick)
            WIN_D:   begin sel_addr = d_addr; sel_mem = d_mem; end
            WIN_W:   begin sel_addr = w_addr; sel_mem = w_mem; end
            default: begin sel_addr = i_addr; sel_mem = i_mem; end
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (any_ok) state_nxt = (sel_mem == 2'd3) ? ACK : GRANT;
            GRANT: if (last_strobe) state_nxt = DRAIN;
            DRAIN: if (q_cs == 3'b111) state_nxt = ACK;
            ACK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_req   <= 1'b0;
            q_i_d   <= 1'b0;
            q_mem   <= 2'd0;
            q_write <= 1'b0;
            q_paddr <= '0;
            win     <= WIN_I;
            rr_last <= 1'b0;
            cnt     <= '0;
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            w_ack   <= 1'b0;
            err     <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            w_ack <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_ok) begin
                        q_paddr <= sel_addr;
                        q_mem   <= sel_mem;
                        q_write <= (pick == WIN_W);
                        q_i_d   <= (pick == WIN_I);
                        win     <= pick;
                        cnt     <= '0;
                        // mem==3 has no chip behind it: skip the controller.
                        q_req   <= (sel_mem != 2'd3);
                    end
                end
                GRANT: begin
                    if (strobe) cnt <= cnt + CW'(1);
                    // Dropped before the controller can resample it.
                    if (last_strobe) q_req <= 1'b0;
                end
                ACK: begin
                    i_ack <= (win == WIN_I);
                    d_ack <= (win == WIN_D);
                    w_ack <= (win == WIN_W);
                    err   <= (q_mem == 2'd3);
                    if (win != WIN_W) rr_last <= (win == WIN_D);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_arb.sv
module tb_qspi_arb;
  localparam int PA = 24;
  localparam int LINE_LENGTH = 4;
  localparam int AW = PA - $clog2(LINE_LENGTH);
  localparam int NSTB = 2 * LINE_LENGTH;

  logic clk, reset;
  logic i_req, d_req, w_req;
  logic [AW-1:0] i_addr, d_addr, w_addr;
  logic [1:0] i_mem, d_mem, w_mem;
  logic i_ack, d_ack, w_ack, err;
  logic q_req, q_i_d, q_write;
  logic [1:0] q_mem;
  logic [AW-1:0] q_paddr;
  logic q_wstrobe_i, q_wstrobe_d, q_rstrobe_d;
  logic [2:0] q_cs;
  logic busy;
  logic [1:0] dbg_state;

  qspi_arb #(.PA(PA), .LINE_LENGTH(LINE_LENGTH)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_mem(i_mem), .i_ack(i_ack),
    .d_req(d_req), .d_addr(d_addr), .d_mem(d_mem), .d_ack(d_ack),
    .w_req(w_req), .w_addr(w_addr), .w_mem(w_mem), .w_ack(w_ack),
    .err(err), .q_req(q_req), .q_i_d(q_i_d), .q_mem(q_mem), .q_write(q_write),
    .q_paddr(q_paddr), .q_wstrobe_i(q_wstrobe_i), .q_wstrobe_d(q_wstrobe_d),
    .q_rstrobe_d(q_rstrobe_d), .q_cs(q_cs), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // grant word: {q_write, q_i_d, q_mem, q_paddr}; ack word: {err, w_ack, d_ack, i_ack}
  logic [AW+3:0] exp_grant_q[$];
  logic [3:0] exp_ack_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  logic prev_q_req = 1'b0;
  always @(negedge clk) begin
    if (q_req && !prev_q_req) begin
      if (exp_grant_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL grant: unexpected grant %0h at %0t", {q_write, q_i_d, q_mem, q_paddr}, $time);
      end else begin
        check("grant", 32'({q_write, q_i_d, q_mem, q_paddr}), 32'(exp_grant_q.pop_front()));
      end
    end
    prev_q_req = q_req;
    if ({err, w_ack, d_ack, i_ack} != 4'b0) begin
      if (exp_ack_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL ack: unexpected ack %0h at %0t", {err, w_ack, d_ack, i_ack}, $time);
      end else begin
        check("ack", 32'({err, w_ack, d_ack, i_ack}), 32'(exp_ack_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic idle_inputs();
    i_req = 0; d_req = 0; w_req = 0;
    i_addr = '0; d_addr = '0; w_addr = '0;
    i_mem = 0; d_mem = 0; w_mem = 0;
    q_wstrobe_i = 0; q_wstrobe_d = 0; q_rstrobe_d = 0;
    q_cs = 3'b111;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    check("reset_outputs", 32'({q_req, q_i_d, q_mem, q_write, q_paddr, i_ack, d_ack, w_ack, err, busy}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_q_req(input string name, input int max_cyc);
    int k;
    for (k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if (q_req) break;
    end
    check(name, 32'(q_req), 32'd1);
  endtask

  task automatic set_strobe(input int kind, input logic stray, input logic v);
    case (kind)
      0: if (stray) q_wstrobe_d = v; else q_wstrobe_i = v;
      1: if (stray) q_wstrobe_i = v; else q_wstrobe_d = v;
      default: if (stray) q_wstrobe_d = v; else q_rstrobe_d = v;
    endcase
  endtask

  // Called at a negedge with q_req high. Strays go in before strobes 1, 3, 5.
  task automatic do_strobes(input int kind, input int strays, input int nstb);
    int st = 0;
    q_cs = 3'b110;
    for (int s = 0; s < nstb; s++) begin
      if (st < strays && (s % 2 == 1)) begin
        set_strobe(kind, 1'b1, 1'b1);
        @(negedge clk);
        set_strobe(kind, 1'b1, 1'b0);
        st++;
      end
      if (s == NSTB - 1) check("q_req_before_last", 32'(q_req), 32'd1);
      set_strobe(kind, 1'b0, 1'b1);
      @(negedge clk);
      set_strobe(kind, 1'b0, 1'b0);
    end
    if (nstb == NSTB) begin
      check("q_req_after_last", 32'(q_req), 32'd0);
      check("busy_drain", 32'(busy), 32'd1);
    end
  endtask

  // Releases chip selects; ack must appear exactly two cycles later.
  task automatic finish_xfer();
    q_cs = 3'b111;
    @(negedge clk);
    check("ack_early", 32'({i_ack, d_ack, w_ack}), 32'd0);
    @(negedge clk);
    check("ack_latency", 32'(i_ack | d_ack | w_ack), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();

    // single icache fill
    apply_reset();
    i_addr = 22'h12345; i_mem = 2'd1; i_req = 1;
    exp_grant_q.push_back({1'b0, 1'b1, 2'd1, 22'h12345});
    exp_ack_q.push_back(4'b0001);
    wait_q_req("fill_latency", 1);
    do_strobes(0, 0, NSTB);
    finish_xfer();
    i_req = 0;
    @(negedge clk);
    check("i_ack_single", 32'(i_ack), 32'd0);

    // writeback beats a simultaneous dcache fill
    apply_reset();
    w_addr = 22'h0ABCD; w_mem = 2'd0; w_req = 1;
    d_addr = 22'h3FFFFF; d_mem = 2'd2; d_req = 1;
    exp_grant_q.push_back({1'b1, 1'b0, 2'd0, 22'h0ABCD});
    exp_grant_q.push_back({1'b0, 1'b0, 2'd2, 22'h3FFFFF});
    exp_ack_q.push_back(4'b0100);
    exp_ack_q.push_back(4'b0010);
    wait_q_req("w_grant", 1);
    check("w_first", 32'(q_write), 32'd1);
    do_strobes(2, 0, NSTB);
    finish_xfer();
    w_req = 0;
    @(negedge clk);
    check("d_after_w", 32'({q_req, q_write}), 32'b10);
    do_strobes(1, 0, NSTB);
    finish_xfer();
    d_req = 0;

    // round-robin: from reset rr_last=0, so d goes first, then i, d, i
    apply_reset();
    i_addr = 22'h00111; i_mem = 2'd0; i_req = 1;
    d_addr = 22'h00222; d_mem = 2'd1; d_req = 1;
    for (int t = 0; t < 4; t++) begin
      if (t % 2 == 0) begin
        exp_grant_q.push_back({1'b0, 1'b0, 2'd1, 22'h00222});
        exp_ack_q.push_back(4'b0010);
      end else begin
        exp_grant_q.push_back({1'b0, 1'b1, 2'd0, 22'h00111});
        exp_ack_q.push_back(4'b0001);
      end
    end
    for (int t = 0; t < 4; t++) begin
      wait_q_req("rr_grant", 2);
      check("rr_side", 32'(q_i_d), 32'(t % 2));
      do_strobes(t % 2 == 0 ? 1 : 0, 0, NSTB);
      finish_xfer();
      if (t == 3) begin i_req = 0; d_req = 0; end
    end

    // mem==3 skips the controller
    apply_reset();
    d_addr = 22'h00001; d_mem = 2'd3; d_req = 1;
    exp_ack_q.push_back(4'b1010);
    @(negedge clk);
    check("inv_no_req_1", 32'({q_req, d_ack, err}), 32'd0);
    @(negedge clk);
    check("inv_ack_err", 32'({q_req, d_ack, err}), 32'b011);
    check("inv_q_mem", 32'(q_mem), 32'd3);
    d_req = 0;
    @(negedge clk);
    check("inv_no_req_3", 32'({q_req, d_ack, err}), 32'd0);

    // stray strobes during a writeback are ignored
    apply_reset();
    w_addr = 22'h2A5A5; w_mem = 2'd1; w_req = 1;
    exp_grant_q.push_back({1'b1, 1'b0, 2'd1, 22'h2A5A5});
    exp_ack_q.push_back(4'b0100);
    wait_q_req("stray_grant", 1);
    do_strobes(2, 3, NSTB);
    finish_xfer();
    w_req = 0;

    // reset mid-transaction, then re-grant of the held request
    apply_reset();
    i_addr = 22'h155AA; i_mem = 2'd2; i_req = 1;
    exp_grant_q.push_back({1'b0, 1'b1, 2'd2, 22'h155AA});
    exp_grant_q.push_back({1'b0, 1'b1, 2'd2, 22'h155AA});
    exp_ack_q.push_back(4'b0001);
    wait_q_req("pre_reset_grant", 1);
    do_strobes(0, 0, 4);
    #2 reset = 1'b1;
    #1 check("async_reset", 32'({q_req, busy, i_ack, d_ack, w_ack, err}), 32'd0);
    q_cs = 3'b111;
    @(negedge clk);
    reset = 1'b0;
    wait_q_req("regrant", 1);
    do_strobes(0, 0, NSTB);
    finish_xfer();
    i_req = 0;
    @(negedge clk);
    @(negedge clk);

    check("grant_q_empty", 32'(exp_grant_q.size()), 32'd0);
    check("ack_q_empty", 32'(exp_ack_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_checks++; n_fail++;
    $display("FAIL watchdog: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
